// File: rtl/less_distance_scanner.sv
// ---------------------------------------------------------------------------
// less_distance_scanner
//
// Serial nearest-value selector. A job is opened by `start` with a non-zero
// `len`; the reference and length are latched. Candidates then stream in over
// a valid/ready handshake, and the scanner keeps the candidate closest to the
// reference. After the last candidate the result is presented until `outAck`.
//
// Handshake: a candidate transfers on a rising edge where inValid && inReady.
// The result transfers on a rising edge where outValid && outAck. inReady and
// outValid never depend on the current cycle's inputs.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   start     in   job request, only looked at in IDLE
//   refI      in   reference value, latched on an accepted start
//   len       in   candidates in the job, latched on an accepted start
//   inValid   in   candidate valid
//   inData    in   candidate value
//   inReady   out  candidate accepted this cycle when inValid is high
//   outValid  out  result valid
//   outData   out  winning candidate
//   outIndex  out  0-based stream position of the winner
//   outDist   out  |winner - reference|
//   outAck    in   result consumed
//   busy      out  high while scanning or holding a result
//   state_o   out  FSM state for debug (0 IDLE, 1 SCAN, 2 DONE)
// ---------------------------------------------------------------------------
module less_distance_scanner #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] refI,
    input  logic [IDX_W-1:0] len,
    input  logic             inValid,
    input  logic [WIDTH-1:0] inData,
    output logic             inReady,
    output logic             outValid,
    output logic [WIDTH-1:0] outData,
    output logic [IDX_W-1:0] outIndex,
    output logic [WIDTH-1:0] outDist,
    input  logic             outAck,
    output logic             busy,
    output logic [1:0]       state_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] ref_q;
    logic [IDX_W-1:0] len_q;
    logic [IDX_W-1:0] count_q;
    logic [WIDTH-1:0] best_data_q;
    logic [IDX_W-1:0] best_idx_q;
    logic [WIDTH-1:0] best_dist_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic [WIDTH-1:0] dist_d;
    logic             accept_d;
    logic             take_d;
    logic [IDX_W-1:0] count_d;
    logic             last_d;

    always_comb begin
        // Larger minus smaller keeps the distance in WIDTH bits without overflow.
        dist_d   = (inData >= ref_q) ? (inData - ref_q) : (ref_q - inData);
        accept_d = in_ready_q && inValid;
        // Strict less-than: on a tie the earlier candidate is kept.
        take_d   = accept_d && ((count_q == '0) || (dist_d < best_dist_q));
        count_d  = count_q + {{(IDX_W-1){1'b0}}, 1'b1};
        last_d   = (count_d == len_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            ref_q       <= '0;
            len_q       <= '0;
            count_q     <= '0;
            best_data_q <= '0;
            best_idx_q  <= '0;
            best_dist_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // A zero-length job has nothing to scan, so it is dropped.
                    if (start && (len != '0)) begin
                        ref_q      <= refI;
                        len_q      <= len;
                        count_q    <= '0;
                        in_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (accept_d) begin
                        count_q <= count_d;
                        if (take_d) begin
                            best_data_q <= inData;
                            best_idx_q  <= count_q;
                            best_dist_q <= dist_d;
                        end
                        if (last_d) begin
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // start is not looked at here; only the ack moves us on.
                    if (outAck) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign inReady  = in_ready_q;
    assign outValid = out_valid_q;
    assign busy     = busy_q;
    assign outData  = best_data_q;
    assign outIndex = best_idx_q;
    assign outDist  = best_dist_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_less_distance_scanner.sv
// ---------------------------------------------------------------------------
// tb_less_distance_scanner
//
// Directed scenarios followed by randomized jobs. Expected results are queued
// in exp_q as {data, index, dist}; directed entries are hand-derived constants,
// random entries come from ref_model over the stream that was sent.
// Inputs change on the falling edge, outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_less_distance_scanner;

    localparam int WIDTH = 8;
    localparam int IDX_W = 4;
    localparam int EW    = WIDTH + IDX_W + WIDTH;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] refI;
    logic [IDX_W-1:0] len;
    logic             inValid;
    logic [WIDTH-1:0] inData;
    logic             inReady;
    logic             outValid;
    logic [WIDTH-1:0] outData;
    logic [IDX_W-1:0] outIndex;
    logic [WIDTH-1:0] outDist;
    logic             outAck;
    logic             busy;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] cand_q[$];
    logic [EW-1:0]    exp_q[$];

    less_distance_scanner #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .refI     (refI),
        .len      (len),
        .inValid  (inValid),
        .inData   (inData),
        .inReady  (inReady),
        .outValid (outValid),
        .outData  (outData),
        .outIndex (outIndex),
        .outDist  (outDist),
        .outAck   (outAck),
        .busy     (busy),
        .state_o  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Nearest candidate: find the smallest distance, then the first position
    // that reaches it.
    function automatic logic [EW-1:0] ref_model(input int r);
        int min_d;
        int pos;
        int d;
        min_d = 1 << 30;
        foreach (cand_q[i]) begin
            d = (int'(cand_q[i]) > r) ? int'(cand_q[i]) - r : r - int'(cand_q[i]);
            if (d < min_d) min_d = d;
        end
        pos = -1;
        foreach (cand_q[i]) begin
            d = (int'(cand_q[i]) > r) ? int'(cand_q[i]) - r : r - int'(cand_q[i]);
            if (pos < 0 && d == min_d) pos = i;
        end
        return {cand_q[pos], IDX_W'(pos), WIDTH'(min_d)};
    endfunction

    task automatic check_result(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_exp_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, outValid, 1);
            check({tag, "_data"},  outData,  e[EW-1 -: WIDTH]);
            check({tag, "_index"}, outIndex, e[WIDTH +: IDX_W]);
            check({tag, "_dist"},  outDist,  e[WIDTH-1:0]);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic start_job(input logic [WIDTH-1:0] r, input logic [IDX_W-1:0] l);
        @(negedge clk);
        start = 1'b1;
        refI  = r;
        len   = l;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("start_busy", busy, (l != 0) ? 1 : 0);
        check("start_ready", inReady, (l != 0) ? 1 : 0);
    endtask

    // Presents one candidate and holds it until it transfers (bounded wait).
    task automatic send(input logic [WIDTH-1:0] d);
        int t;
        t = 0;
        @(negedge clk);
        inValid = 1'b1;
        inData  = d;
        while (!inReady && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!inReady) begin
            check("send_timeout", 0, 1);
            inValid = 1'b0;
        end else begin
            check("valid_early", outValid, 0);
            @(posedge clk);
            #1;
            inValid = 1'b0;
        end
    endtask

    // gap < 0 picks 0..2 idle cycles at random before each candidate.
    task automatic run_job(input string tag, input logic [WIDTH-1:0] r, input int gap);
        int g;
        start_job(r, IDX_W'(cand_q.size()));
        foreach (cand_q[i]) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int k = 0; k < g; k++) begin
                @(negedge clk);
                inData = $urandom;
                check({tag, "_stall_ready"}, inReady, 1);
                check({tag, "_stall_valid"}, outValid, 0);
            end
            send(cand_q[i]);
        end
        // One cycle after the last transfer the result must be up.
        @(negedge clk);
        check_result(tag);
        check({tag, "_done_ready"}, inReady, 0);
        check({tag, "_done_busy"}, busy, 1);
    endtask

    task automatic do_ack();
        @(negedge clk);
        outAck = 1'b1;
        @(posedge clk);
        #1;
        outAck = 1'b0;
        @(negedge clk);
        check("ack_valid", outValid, 0);
        check("ack_busy", busy, 0);
        check("ack_ready", inReady, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [WIDTH-1:0] hold_data;
        logic [IDX_W-1:0] hold_idx;
        logic [WIDTH-1:0] hold_dist;
        int r;
        int l;

        rst = 1'b1;
        start = 1'b0;
        refI = '0;
        len = '0;
        inValid = 1'b0;
        inData = '0;
        outAck = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", inReady, 0);
        check("rst_valid", outValid, 0);
        check("rst_busy",  busy, 0);
        check("rst_data",  outData, 0);
        check("rst_index", outIndex, 0);
        check("rst_dist",  outDist, 0);
        rst = 1'b0;

        // Reset in the middle of a scan discards the job at once.
        start_job(8'd20, 4'd5);
        send(8'd30);
        send(8'd40);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_valid", outValid, 0);
        check("midrst_ready", inReady, 0);
        check("midrst_busy",  busy, 0);
        check("midrst_data",  outData, 0);
        @(negedge clk);
        rst = 1'b0;
        cand_q = '{8'd7};
        exp_q.push_back({8'd7, 4'd0, 8'd93});
        run_job("after_rst", 8'd100, 0);
        do_ack();

        // Basic
        cand_q = '{8'd10, 8'd60, 8'd45, 8'd200};
        exp_q.push_back({8'd45, 4'd2, 8'd5});
        run_job("basic", 8'd50, 0);
        do_ack();

        // Ties: the earlier candidate wins
        cand_q = '{8'd90, 8'd110, 8'd95};
        exp_q.push_back({8'd95, 4'd2, 8'd5});
        run_job("tie3", 8'd100, 0);
        do_ack();
        cand_q = '{8'd90, 8'd110};
        exp_q.push_back({8'd90, 4'd0, 8'd10});
        run_job("tie2", 8'd100, 1);

        // Result held in DONE: inValid and start are ignored
        hold_data = outData;
        hold_idx  = outIndex;
        hold_dist = outDist;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", outValid, 1);
            check("hold_ready", inReady, 0);
            check("hold_data",  outData, hold_data);
            check("hold_index", outIndex, hold_idx);
            check("hold_dist",  outDist, hold_dist);
            inValid = 1'b1;
            inData  = $urandom;
            start   = (k == 2);
        end
        @(negedge clk);
        check("hold_data_end", outData, 8'd90);
        inValid = 1'b0;
        start   = 1'b0;
        // start presented together with the ack must not open a job
        outAck = 1'b1;
        start  = 1'b1;
        @(posedge clk);
        #1;
        outAck = 1'b0;
        start  = 1'b0;
        @(negedge clk);
        check("ack_start_busy", busy, 0);
        check("ack_start_valid", outValid, 0);
        @(negedge clk);
        check("ack_start_busy2", busy, 0);
        check("idle_keeps_data", outData, 8'd90);

        // Extremes with idle cycles between candidates
        cand_q = '{8'd255, 8'd254, 8'd255};
        exp_q.push_back({8'd254, 4'd1, 8'd254});
        run_job("extreme", 8'd0, 2);
        do_ack();

        // Zero-length start is ignored
        start_job(8'd5, 4'd0);
        @(negedge clk);
        check("len0_busy", busy, 0);

        // Longest job
        cand_q.delete();
        for (int v = 15; v >= 1; v--) cand_q.push_back(WIDTH'(v));
        exp_q.push_back({8'd1, 4'd14, 8'd1});
        run_job("len15", 8'd0, 0);
        do_ack();

        // Randomized jobs against the reference model
        for (int j = 0; j < 25; j++) begin
            r = $urandom_range(0, 255);
            l = $urandom_range(1, 15);
            cand_q.delete();
            for (int i = 0; i < l; i++) begin
                // Narrow windows make ties and near-ties common.
                if (j % 2 == 0) cand_q.push_back(WIDTH'($urandom_range(0, 255)));
                else            cand_q.push_back(WIDTH'((r + $urandom_range(0, 8)) & 255));
            end
            exp_q.push_back(ref_model(r));
            run_job("rand", WIDTH'(r), -1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_ack();
        end

        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/less_distance_scanner.md
Name: less_distance_scanner

Overview:
- Sequential counterpart of the combinational two-input nearest-value selector.
- Consumes a stream of candidates over a valid/ready handshake against a latched reference.
- Returns the candidate closest to the reference, plus its position in the stream and its distance.
- Sits downstream of a sample source and replaces a tree of two-input selectors when candidates arrive serially.

Parameters:
- WIDTH, 8, bit width of reference, candidates and distance.
- IDX_W, 4, bit width of the length and index fields; at most 2^IDX_W-1 candidates per job.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  job request; sampled only in IDLE.
- refI  in  WIDTH  reference value; latched on accepted start.
- len  in  IDX_W  number of candidates in the job; latched on accepted start.
- inValid  in  1  candidate valid.
- inData  in  WIDTH  candidate value.
- inReady  out  1  scanner accepts a candidate this cycle.
- outValid  out  1  result valid.
- outData  out  WIDTH  winning candidate.
- outIndex  out  IDX_W  0-based stream position of the winner.
- outDist  out  WIDTH  |winner - refI|.
- outAck  in  1  result consumed.
- busy  out  1  high in SCAN and DONE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. inReady, outValid, busy, outData, outIndex, outDist and internal count/best all =0. Reset mid-job discards the job.
- States: IDLE, SCAN, DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - start=1 and len!=0: latch refI and len, clear count, go to SCAN next edge.
  - start=1 and len==0: ignored, stay in IDLE.
- SCAN:
  - inReady=1, busy=1.
  - A candidate is accepted on an edge where inValid&&inReady.
  - dist = |inData - refReg|, computed unsigned at WIDTH bits with no overflow (larger minus smaller).
  - Best is updated when it is the first accepted candidate (count==0) or when dist < bestDist. The comparison is strict: on a tie the earlier candidate wins.
  - count increments on each accept.
  - When the accept makes count==lenReg, go to DONE on that same edge. Results are registered, so outValid=1 in the cycle after the last accept (latency 1).
  - inValid=0 cycles stall with no state change.
- DONE:
  - inReady=0, outValid=1; outData/outIndex/outDist hold steady.
  - outAck=1 on an edge: go to IDLE, outValid=0 next cycle. Result registers keep their values until the next job's first accept.
- start outside IDLE is ignored; it is not queued.
- inValid while inReady=0 is ignored; nothing is consumed.
- A start and an outAck in the same DONE cycle: only the ack is taken. start must be re-presented in IDLE.
- Maximum job length is 2^IDX_W-1 (15 at defaults). count must not wrap.

Test Plan:
- Reset: assert rst mid-SCAN after 2 accepts -> immediately outValid=0, inReady=0, busy=0. After release, start with refI=100, len=1, candidate 7 -> outData=7, outIndex=0, outDist=93.
- Basic: refI=50, len=4, stream 10,60,45,200 -> outData=45, outIndex=2, outDist=5. outValid rises exactly 1 cycle after the 4th accept.
- Tie: refI=100, len=3, stream 90,110,95 -> outData=95, outIndex=2, outDist=5. Second stream 90,110 with len=2 -> outData=90, outIndex=0, outDist=10 (earlier wins).
- Extremes/stalls: refI=0, len=3, stream 255,254,255 with 2 idle cycles between accepts -> outData=254, outIndex=1, outDist=254. No spurious accepts during the idle cycles.
- Handshake: hold outAck=0 for 5 cycles in DONE -> outputs stable and inValid ignored. Pulse start during DONE -> ignored. Then outAck=1 -> IDLE next cycle.
- len=0 start -> stays IDLE, busy=0. len=15 with stream 15..1 and refI=0 -> outData=1, outIndex=14, outDist=1.
